// File: rtl/pkwars_input_pkg.sv
// Shared definitions for the PKWARS input conditioning stage: CTR bit
// positions, coin FSM states and the pending-coin counter width.
package pkwars_input_pkg;

  // Bit positions inside the active-low CTR1/CTR2 bytes
  localparam int CTR_LF   = 0;
  localparam int CTR_RG   = 1;
  localparam int CTR_TA   = 2;
  localparam int CTR_ST   = 5;
  localparam int CTR_COIN = 7;

  // Pending coin counter
  localparam int              PEND_W   = 3;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  // Frame counter width covers COIN_PULSE_FRAMES / COIN_GAP_FRAMES up to 15
  localparam int FRM_W = 4;

  typedef enum logic [1:0] {
    COIN_IDLE  = 2'd0,
    COIN_PULSE = 2'd1,
    COIN_GAP   = 2'd2
  } coin_state_e;

endpackage

// File: rtl/pkwars_input_ctl_if.sv
// Bundle of the game-facing signals of pkwars_input_ctl: raw controls and
// VBLK in, conditioned CTR bytes and the pending-coin debug count out.
interface pkwars_input_ctl_if;
  logic       VBLK;
  logic [3:0] P1;
  logic [3:0] P2;
  logic [1:0] COIN;
  logic [7:0] CTR1;
  logic [7:0] CTR2;
  logic [2:0] COIN_PEND;

  // Drives raw inputs, observes conditioned outputs
  modport master (
    output VBLK, P1, P2, COIN,
    input  CTR1, CTR2, COIN_PEND
  );

  // The conditioning block itself
  modport slave (
    input  VBLK, P1, P2, COIN,
    output CTR1, CTR2, COIN_PEND
  );
endinterface

// File: rtl/pkwars_debounce.sv
// Two-flop synchroniser followed by a per-bit debouncer. A bit's debounced
// value only follows the synchronised input after it has differed for
// DEBOUNCE_CYCLES consecutive clocks; anything shorter is swallowed.
module pkwars_debounce #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 48000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] dbc_q;
  logic [WIDTH-1:0] dbc_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Metastability guard for the asynchronous raw inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive disagreement; flip the debounced bit at the terminal count
  always_comb begin
    dbc_d = dbc_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != dbc_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          dbc_d[i] = ~dbc_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbc_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      dbc_q <= dbc_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign dout = dbc_q;

endmodule

// File: rtl/pkwars_input_ctl.sv
// Input conditioning for the FPGA_PKWARS core: debounces player controls and
// coin switches, turns coin presses into frame-locked pulses with a forced
// gap, and registers the active-low CTR1/CTR2 bytes.
// Optional build macro PKWARS_INPUT_SOCD_EN: when defined, a player's left and
// right both pressed are presented as both released.
module pkwars_input_ctl
  import pkwars_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 48000,
  parameter int COIN_PULSE_FRAMES = 4,
  parameter int COIN_GAP_FRAMES   = 4
) (
  input  logic               clk_sys,
  input  logic               RESET_N,
  pkwars_input_ctl_if.slave  bus
);

  localparam logic [FRM_W-1:0] PULSE_LOAD = FRM_W'(COIN_PULSE_FRAMES);
  localparam logic [FRM_W-1:0] GAP_LOAD   = FRM_W'(COIN_GAP_FRAMES);

  logic [9:0]        raw_in;
  logic [9:0]        dbc;
  logic [3:0]        p1_dbc;
  logic [3:0]        p2_dbc;
  logic [1:0]        coin_dbc;
  logic [3:0]        p1_clean;
  logic [3:0]        p2_clean;

  logic              vblk_sync1_q;
  logic              vblk_sync2_q;
  logic              vblk_prev_q;
  logic              frame_tick;

  logic              coin_any;
  logic              coin_prev_q;
  logic              coin_req;

  coin_state_e       state_q;
  coin_state_e       state_d;
  logic [FRM_W-1:0]  frm_cnt_q;
  logic [FRM_W-1:0]  frm_cnt_d;
  logic [PEND_W-1:0] pend_q;
  logic [PEND_W-1:0] pend_d;
  logic              pend_dec;
  logic              coinp;

  logic [7:0]        ctr1_q;
  logic [7:0]        ctr1_d;
  logic [7:0]        ctr2_q;
  logic [7:0]        ctr2_d;

  assign raw_in = {bus.COIN, bus.P2, bus.P1};

  pkwars_debounce #(
    .WIDTH           (10),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk_sys),
    .rst_n (RESET_N),
    .din   (raw_in),
    .dout  (dbc)
  );

  assign p1_dbc   = dbc[3:0];
  assign p2_dbc   = dbc[7:4];
  assign coin_dbc = dbc[9:8];

  // VBLK synchroniser and rising-edge history for the frame tick
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      vblk_sync1_q <= 1'b0;
      vblk_sync2_q <= 1'b0;
      vblk_prev_q  <= 1'b0;
    end else begin
      vblk_sync1_q <= bus.VBLK;
      vblk_sync2_q <= vblk_sync1_q;
      vblk_prev_q  <= vblk_sync2_q;
    end
  end

  assign frame_tick = vblk_sync2_q & ~vblk_prev_q;

  // Either coin switch counts; a request is the rising edge of their union
  assign coin_any = coin_dbc[0] | coin_dbc[1];
  assign coin_req = coin_any & ~coin_prev_q;

  // Coin FSM next state and pending counter update
  always_comb begin
    state_d   = state_q;
    frm_cnt_d = frm_cnt_q;
    pend_d    = pend_q;
    pend_dec  = 1'b0;

    unique case (state_q)
      COIN_IDLE: begin
        if (frame_tick && (pend_q != '0)) begin
          state_d   = COIN_PULSE;
          frm_cnt_d = PULSE_LOAD;
          pend_dec  = 1'b1;
        end
      end
      COIN_PULSE: begin
        if (frame_tick) begin
          if (frm_cnt_q == FRM_W'(1)) begin
            state_d   = COIN_GAP;
            frm_cnt_d = GAP_LOAD;
          end else begin
            frm_cnt_d = frm_cnt_q - 1'b1;
          end
        end
      end
      COIN_GAP: begin
        if (frame_tick) begin
          if (frm_cnt_q == FRM_W'(1)) begin
            state_d   = COIN_IDLE;
            frm_cnt_d = '0;
          end else begin
            frm_cnt_d = frm_cnt_q - 1'b1;
          end
        end
      end
      default: begin
        state_d   = COIN_IDLE;
        frm_cnt_d = '0;
      end
    endcase

    // A request landing on the consuming tick cancels out, except at
    // saturation where the request was already being dropped.
    unique case ({coin_req, pend_dec})
      2'b10: begin
        if (pend_q != PEND_MAX) pend_d = pend_q + 1'b1;
      end
      2'b01: pend_d = pend_q - 1'b1;
      2'b11: begin
        if (pend_q == PEND_MAX) pend_d = pend_q - 1'b1;
      end
      default: pend_d = pend_q;
    endcase
  end

  // Coin FSM, frame counter, pending counter and coin edge history
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= COIN_IDLE;
      frm_cnt_q   <= '0;
      pend_q      <= '0;
      coin_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frm_cnt_q   <= frm_cnt_d;
      pend_q      <= pend_d;
      coin_prev_q <= coin_any;
    end
  end

  assign coinp = (state_q == COIN_PULSE);

  // Optional left/right cleaning, then assembly of the active-low bytes
  always_comb begin
    p1_clean = p1_dbc;
    p2_clean = p2_dbc;
`ifdef PKWARS_INPUT_SOCD_EN
    if (p1_dbc[0] && p1_dbc[1]) p1_clean[1:0] = 2'b00;
    if (p2_dbc[0] && p2_dbc[1]) p2_clean[1:0] = 2'b00;
`else
    p1_clean = p1_dbc;
    p2_clean = p2_dbc;
`endif

    ctr1_d         = 8'hFF;
    ctr1_d[CTR_LF] = ~p1_clean[0];
    ctr1_d[CTR_RG] = ~p1_clean[1];
    ctr1_d[CTR_TA] = ~p1_clean[2];
    ctr1_d[CTR_ST] = ~p1_clean[3];

    ctr2_d           = 8'hFF;
    ctr2_d[CTR_LF]   = ~p2_clean[0];
    ctr2_d[CTR_RG]   = ~p2_clean[1];
    ctr2_d[CTR_TA]   = ~p2_clean[2];
    ctr2_d[CTR_ST]   = ~p2_clean[3];
    ctr2_d[CTR_COIN] = ~coinp;
  end

  // Output register toward the core
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      ctr1_q <= 8'hFF;
      ctr2_q <= 8'hFF;
    end else begin
      ctr1_q <= ctr1_d;
      ctr2_q <= ctr2_d;
    end
  end

  assign bus.CTR1      = ctr1_q;
  assign bus.CTR2      = ctr2_q;
  assign bus.COIN_PEND = pend_q;

endmodule
